// File: rtl/rv_pkg.sv
// Shared encodings for the writeback path: datapath width, writeback source
// select and load funct3 values.
package rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a raw memory word and sign- or
// zero-extends it to the datapath width.
module load_extend
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? raw[31:16] : raw[15:0];
    ext      = '0;
    unique case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   ext = raw;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register: selects the writeback source, drives the
// register bank write port and counts retired instructions.
module mem_wb_writeback
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic             stall,
  input  logic             flush,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_write_data,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_next;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .raw    (mem_load_data),
    .offset (mem_alu_result[1:0]),
    .funct3 (mem_funct3),
    .ext    (load_val)
  );

  always_comb begin
    wb_next = '0;
    unique case (wb_sel_e'(mem_wb_sel))
      WB_SEL_ALU:  wb_next = mem_alu_result;
      WB_SEL_LOAD: wb_next = load_val;
      WB_SEL_PC4:  wb_next = mem_pc_plus4;
      default:     wb_next = '0;
    endcase
  end

  // Flush beats stall so a squashed instruction never writes back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_write_data <= '0;
      instret       <= '0;
    end else if (flush) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_write_data <= '0;
    end else if (!stall) begin
      wb_valid      <= mem_valid;
      wb_reg_write  <= mem_valid & mem_reg_write & (mem_rd != 5'd0);
      wb_rd         <= mem_rd;
      wb_write_data <= wb_next;
      if (mem_valid) instret <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback with a small negedge-written register
// bank model; counter shortened to 4 bits so the wrap is reachable.
module tb_mem_wb_writeback;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             mem_valid, mem_reg_write, stall, flush;
  logic [4:0]       mem_rd;
  logic [1:0]       mem_wb_sel;
  logic [2:0]       mem_funct3;
  logic [XLEN-1:0]  mem_alu_result, mem_load_data, mem_pc_plus4;
  logic             wb_valid, wb_reg_write;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_write_data;
  logic [CNT_W-1:0] instret;

  logic [XLEN-1:0]  regs [32];
  int tests = 0;
  int fails = 0;

  mem_wb_writeback #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_pc_plus4(mem_pc_plus4), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_write_data(wb_write_data), .instret(instret)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (wb_reg_write) regs[wb_rd] <= wb_write_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                        input logic [31:0] d, input logic [3:0] cnt);
    chk({tag, ".valid"}, 64'(wb_valid), 64'(v));
    chk({tag, ".rw"}, 64'(wb_reg_write), 64'(rw));
    chk({tag, ".rd"}, 64'(wb_rd), 64'(rd));
    chk({tag, ".data"}, 64'(wb_write_data), 64'(d));
    chk({tag, ".instret"}, 64'(instret), 64'(cnt));
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc4);
    mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_funct3 = f3; mem_alu_result = alu; mem_load_data = ld; mem_pc_plus4 = pc4;
  endtask

  // advance to just after the next capture edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] W = 32'h80F1_7F02;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 2'b00, 3'b000, 0, 0, 0);
    step();
    chk_wb("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    drive(1, 1, 5, 2'b00, 3'b000, 32'h0000_1234, 0, 0);
    step();
    chk_wb("alu", 1, 1, 5, 32'h1234, 1);

    drive(0, 1, 9, 2'b00, 3'b000, 32'hDEAD, 0, 0);
    step();
    chk("regbank.x5", 64'(regs[5]), 64'h1234);
    chk_wb("bubble", 0, 0, 9, 32'hDEAD, 1);

    drive(1, 1, 3, 2'b01, 3'b000, 32'h1002, W, 0); step();
    chk_wb("lb", 1, 1, 3, 32'hFFFF_FFF1, 2);
    drive(1, 1, 3, 2'b01, 3'b100, 32'h1002, W, 0); step();
    chk_wb("lbu", 1, 1, 3, 32'h0000_00F1, 3);
    drive(1, 1, 3, 2'b01, 3'b001, 32'h1002, W, 0); step();
    chk_wb("lh", 1, 1, 3, 32'hFFFF_80F1, 4);
    drive(1, 1, 3, 2'b01, 3'b101, 32'h1000, W, 0); step();
    chk_wb("lhu", 1, 1, 3, 32'h0000_7F02, 5);
    drive(1, 1, 3, 2'b01, 3'b010, 32'h1003, W, 0); step();
    chk_wb("lw", 1, 1, 3, W, 6);
    drive(1, 1, 3, 2'b01, 3'b011, 32'h1000, W, 0); step();
    chk_wb("f3_011", 1, 1, 3, 0, 7);

    drive(1, 1, 0, 2'b00, 3'b000, 32'h55, 0, 0); step();
    chk_wb("x0", 1, 0, 0, 32'h55, 8);
    drive(1, 1, 4, 2'b11, 3'b000, 32'h77, 0, 32'h99); step();
    chk_wb("rsvd_sel", 1, 1, 4, 0, 9);

    drive(1, 1, 1, 2'b10, 3'b000, 32'h40, 0, 32'h100); step();
    chk_wb("jal", 1, 1, 1, 32'h100, 10);
    stall = 1'b1;
    drive(1, 1, 7, 2'b00, 3'b000, 32'hBEEF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_wb("stall", 1, 1, 1, 32'h100, 10);
    end
    chk("regbank.x1", 64'(regs[1]), 64'h100);
    flush = 1'b1;
    step();
    chk_wb("stall_flush", 0, 0, 0, 0, 10);
    stall = 1'b0; flush = 1'b0;

    drive(1, 1, 6, 2'b00, 3'b000, 32'h66, 0, 0); step();
    chk_wb("pre_reset", 1, 1, 6, 32'h66, 11);
    stall = 1'b1;
    #2 reset = 1'b1;
    #1 chk_wb("async_reset", 0, 0, 0, 0, 0);
    step();
    chk_wb("reset_hold", 0, 0, 0, 0, 0);
    reset = 1'b0; stall = 1'b0;

    drive(1, 1, 2, 2'b00, 3'b000, 32'h22, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i == 1) chk_wb("post_reset", 1, 1, 2, 32'h22, 1);
    end
    chk("instret.max", 64'(instret), 64'hF);
    step();
    chk("instret.wrap", 64'(instret), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
Writer-side counterpart to the register bank. This block is the MEM/WB pipeline register plus writeback logic.
- Captures MEM-stage results and selects the writeback source (ALU, load, PC+4).
- Aligns and sign/zero-extends load data.
- Drives the register bank's rd/write_data/reg_write port.
- Keeps a 64-bit retired-instruction counter.

Parameters:
XLEN, 32, datapath width
CNT_W, 64, width of retired-instruction counter

Ports:
clk  in  1  pipeline clock; WB state updates on posedge
reset  in  1  asynchronous, active-high reset
mem_valid  in  1  MEM stage holds a real instruction
mem_reg_write  in  1  instruction writes rd
mem_rd  in  5  destination register
mem_wb_sel  in  2  writeback source select
mem_funct3  in  3  load type
mem_alu_result  in  XLEN  ALU result / load effective address
mem_load_data  in  XLEN  raw aligned word from data memory
mem_pc_plus4  in  XLEN  link value for jal/jalr
stall  in  1  hold WB contents
flush  in  1  insert bubble into WB
wb_valid  out  1  WB holds a real instruction
wb_reg_write  out  1  write enable to register bank
wb_rd  out  5  write address to register bank
wb_write_data  out  XLEN  write data to register bank
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, active-high): all outputs are 0 immediately and stay 0 while reset is high.
- Latency: 1 cycle. Values captured at posedge N appear on the outputs after that edge.
- The register bank writes on the following negedge, so decode reads in the same cycle see the new value without forwarding.
- Priority at each posedge: reset > flush > stall > capture.
  - flush: wb_valid, wb_reg_write and wb_rd go to 0; wb_write_data goes to 0; instret unchanged.
  - stall (no flush): all registers hold. wb_reg_write may stay asserted across several negedges, rewriting the same value; this is legal.
  - capture: wb_valid <= mem_valid; wb_rd <= mem_rd; wb_write_data <= the selected value.
- wb_reg_write <= mem_valid & mem_reg_write & (mem_rd != 0). It is never 1 for x0 or for a bubble.
- wb_sel encoding:
  - 00: mem_alu_result
  - 01: extended load value
  - 10: mem_pc_plus4
  - 11: reserved; selects 0
- Load extension uses byte offset a = mem_alu_result[1:0]:
  - LB (000) / LBU (100): byte at a, sign- or zero-extended.
  - LH (001) / LHU (101): halfword at a[1] (a[0] ignored), sign- or zero-extended.
  - LW (010): full word; a ignored.
  - 011, 110, 111: result 0.
- instret increments by 1 on every capture edge with mem_valid=1.
  - It does not increment on stall or flush edges, so a stalled instruction is counted once.
  - It wraps from all-ones to 0.
- Reset mid-stall or mid-flush clears everything. The first capture after reset release behaves normally.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package rv_pkg:
  - WB_SEL_ALU/LOAD/PC4/RSVD constants
  - load funct3 constants F3_LB/LH/LW/LBU/LHU
  - XLEN
- Sub-module load_extend (combinational): inputs raw word, offset[1:0], funct3; output extended XLEN value. It is instantiated once before the capture register.

Test Plan:
- Reset: assert reset mid-cycle with wb_valid=1 and instret=5 -> all outputs 0 immediately, without waiting for a clock edge.
- ALU writeback: mem_valid=1, reg_write=1, rd=5, sel=00, alu=0x0000_1234 -> next cycle wb_rd=5, wb_write_data=0x1234, wb_reg_write=1, instret=1; register x5 reads 0x1234 after the negedge.
- Loads: word 0x80F1_7F02.
  - LB a=2 -> 0xFFFF_FFF1
  - LBU a=2 -> 0x0000_00F1
  - LH a=2 -> 0xFFFF_80F1
  - LHU a=0 -> 0x0000_7F02
  - LW a=3 -> 0x80F1_7F02
  - funct3=011 -> 0
- x0 and bubble:
  - rd=0, reg_write=1, valid=1 -> wb_reg_write=0, instret increments.
  - valid=0 -> wb_reg_write=0, instret unchanged.
- Stall/flush:
  - capture JAL with sel=10, pc4=0x100, rd=1; hold stall 3 cycles -> outputs held, instret +1 total.
  - assert stall and flush together -> bubble, wb_reg_write=0.
- Wrap: force instret to all-ones via 2^64-1 valid captures (or a bench-only shortened CNT_W=4 after 15 captures) -> next valid capture gives 0.
